alarm_sequencer: RTL and testbench
==================================

ALARM_SEQUENCER -- requirements
Module: alarm_sequencer

Interface
REQ-001 SHALL have parameter N_CH, default 4: number of alarm channels (2..16).
REQ-002 SHALL have parameter STEPS, default 4: tones per melody (2..16).
REQ-003 SHALL have parameter DIV_W, default 8: half-period counter width.
REQ-004 SHALL have parameter BASE_HALF, default 2: half-period, in clk cycles, of tone index 0 (minimum 1).
REQ-005 SHALL have parameter STEP_HALF, default 1: half-period increment per tone index; BASE_HALF+(STEPS-1)*STEP_HALF SHALL be < 2^DIV_W.
REQ-006 SHALL have parameter REPEATS, default 2: melody plays per alarm when ALARM_REPEAT_EN is defined (1..15).
REQ-007 clk  input  1  system clock; one clock, synchronous design.
REQ-008 rst  input  1  reset; synchronous, active-high.
REQ-009 clk_1hz_posedge  input  1  one-cycle tick strobe that paces melody steps.
REQ-010 ring  input  N_CH  alarm requests; bit 0 is highest priority.
REQ-011 stop  input  1  cancels the currently playing alarm.
REQ-012 speaker  output  1  square-wave drive.
REQ-013 busy  output  1  high while a melody plays.
REQ-014 cur_ch  output  clog2(N_CH)  channel now playing.
REQ-015 cur_step  output  clog2(STEPS)  melody step now playing.
REQ-016 pending  output  N_CH  latched, not yet completed requests (including the playing one).

Function
REQ-017 A 0->1 edge on ring[i] SHALL set pending[i] on the next clk edge; level-high without an edge SHALL set nothing.
REQ-018 An edge on ring[i] while channel i is playing or already pending SHALL be ignored.
REQ-019 The FSM SHALL have states IDLE and PLAY; IDLE->PLAY when pending is nonzero, selecting the lowest set index; the request edge-to-busy latency SHALL be 2 cycles.
REQ-020 Entering PLAY for a channel SHALL set cur_step=0, half-period counter=0 and speaker=0.
REQ-021 In PLAY, each clk_1hz_posedge SHALL advance cur_step by 1; on the tick where cur_step==STEPS-1, the melody SHALL end.
REQ-022 A tick coinciding with the cycle PLAY is entered SHALL be ignored.
REQ-023 Tone index t SHALL be cur_step for even channels (falling pitch) and STEPS-1-cur_step for odd channels (rising pitch).
REQ-024 Half-period H SHALL equal BASE_HALF+t*STEP_HALF, evaluated at DIV_W bits.
REQ-025 The counter SHALL increment every clk; at H-1 it SHALL wrap to 0 and speaker SHALL toggle.
REQ-026 Every step change SHALL reset the counter to 0 and speaker to 0.
REQ-027 On melody end, pending[cur_ch] SHALL clear; the FSM SHALL then go to PLAY on the next lowest pending channel in the same cycle, or to IDLE.
REQ-028 A new edge on ring[j] with j<cur_ch SHALL preempt: the next cycle plays j from step 0, and cur_ch stays pending and restarts from step 0 later.
REQ-029 stop in PLAY SHALL clear pending[cur_ch] and end the melody as in REQ-027; stop in IDLE SHALL be ignored.
REQ-030 When stop and a ring edge on another channel occur in the same cycle, both SHALL take effect.
REQ-031 In IDLE, speaker, busy, cur_ch and cur_step SHALL be 0.

Reset
REQ-032 rst SHALL zero pending, the FSM (IDLE), counter, speaker, busy, cur_ch, cur_step and edge-detect history on the next clk edge, overriding every other input including mid-melody.
REQ-033 ring bits held high through reset release SHALL NOT register as edges.

Configuration
REQ-034 With ALARM_REPEAT_EN defined, a melody SHALL replay from step 0 until it has played REPEATS times before the channel completes; stop SHALL cancel all remaining repeats.
REQ-035 Without ALARM_REPEAT_EN, each alarm SHALL play once, the repeat counter SHALL NOT exist, and REPEATS SHALL be ignored.

Verification
REQ-036 Pulse ring=4'b0001 -> busy=1 two cycles later, cur_ch=0, speaker period 4 clk; 4 ticks later busy=0, pending=0.
REQ-037 Assert ring=4'b0110 simultaneously -> ch1 plays first with H=5,4,3,2 across steps; ch2 then follows with H=2,3,4,5.
REQ-038 While ch3 is at step 2, pulse ring[0] -> cur_ch=0, cur_step=0; after ch0 ends, ch3 replays from step 0.
REQ-039 Pulse stop during ch0 step 1 with ring[2] pending -> next cycle cur_ch=2, cur_step=0, pending=4'b0100.
REQ-040 Assert rst mid-melody while ring[0] is held high -> speaker=0, busy=0 next edge; no restart after release.
REQ-041 With ALARM_REPEAT_EN defined and REPEATS=2 -> ch0 busy for 8 ticks; stop at tick 5 -> busy=0 next cycle.

Source files
------------

// File: rtl/alarm_sequencer.sv
// Prioritised alarm melody player: latches ring edges, plays a stepped square-wave melody per channel.
// Optional build macro ALARM_REPEAT_EN replays each melody REPEATS times before the channel completes.
module alarm_sequencer #(
  parameter int N_CH      = 4,
  parameter int STEPS     = 4,
  parameter int DIV_W     = 8,
  parameter int BASE_HALF = 2,
  parameter int STEP_HALF = 1,
  parameter int REPEATS   = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clk_1hz_posedge,
  input  logic [N_CH-1:0]          ring,
  input  logic                     stop,
  output logic                     speaker,
  output logic                     busy,
  output logic [$clog2(N_CH)-1:0]  cur_ch,
  output logic [$clog2(STEPS)-1:0] cur_step,
  output logic [N_CH-1:0]          pending
);
  localparam int CW = $clog2(N_CH);
  localparam int SW = $clog2(STEPS);

  typedef enum logic {IDLE = 1'b0, PLAY = 1'b1} state_t;

  function automatic logic [CW-1:0] lowest(input logic [N_CH-1:0] v);
    logic [CW-1:0] r;
    r = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (v[i]) r = CW'(i);
    end
    return r;
  endfunction

  state_t           state;
  logic [N_CH-1:0]  ring_q;
  logic             armed;
  logic             fresh;
  logic [DIV_W-1:0] cnt;
`ifdef ALARM_REPEAT_EN
  logic [3:0]       rep;
`endif

  logic [N_CH-1:0]  rise_s, oh_s, others_s;
  logic [CW-1:0]    lo_all_s, lo_oth_s, start_ch_s;
  logic [SW-1:0]    tone_s;
  logic [DIV_W-1:0] half_s;
  logic             tick_ok_s, last_step_s, last_rep_s;
  logic             start_s, idle_s, end_s, adv_s;

  // Armed gating keeps a ring held high through reset from looking like an edge.
  always_comb begin
    rise_s      = ring & ~ring_q & {N_CH{armed}};
    oh_s        = {{(N_CH-1){1'b0}}, 1'b1} << cur_ch;
    others_s    = pending & ~oh_s;
    lo_all_s    = lowest(pending);
    lo_oth_s    = lowest(others_s);
    tone_s      = cur_ch[0] ? (SW'(STEPS - 1) - cur_step) : cur_step;
    half_s      = DIV_W'(BASE_HALF) + DIV_W'(tone_s) * DIV_W'(STEP_HALF);
    tick_ok_s   = clk_1hz_posedge & ~fresh;
    last_step_s = (cur_step == SW'(STEPS - 1));
`ifdef ALARM_REPEAT_EN
    last_rep_s  = (rep == 4'(REPEATS - 1));
`else
    last_rep_s  = 1'b1;
`endif
    start_s    = 1'b0;
    start_ch_s = '0;
    idle_s     = 1'b0;
    end_s      = 1'b0;
    adv_s      = 1'b0;
    case (state)
      IDLE: begin
        if (|pending) begin
          start_s    = 1'b1;
          start_ch_s = lo_all_s;
        end else begin
          idle_s = 1'b1;
        end
      end
      PLAY: begin
        if (stop || (tick_ok_s && last_step_s && last_rep_s)) begin
          end_s = 1'b1;
          if (|others_s) begin
            start_s    = 1'b1;
            start_ch_s = lo_oth_s;
          end else begin
            idle_s = 1'b1;
          end
        end else if (lo_all_s < cur_ch) begin
          start_s    = 1'b1;
          start_ch_s = lo_all_s;
        end else if (tick_ok_s) begin
          adv_s = 1'b1;
        end else begin
          adv_s = 1'b0;
        end
      end
      default: idle_s = 1'b1;
    endcase
  end

  // Sequencer state, request latch and tone generator.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ring_q   <= '0;
      armed    <= 1'b0;
      fresh    <= 1'b0;
      cnt      <= '0;
      speaker  <= 1'b0;
      busy     <= 1'b0;
      cur_ch   <= '0;
      cur_step <= '0;
      pending  <= '0;
`ifdef ALARM_REPEAT_EN
      rep      <= 4'd0;
`endif
    end else begin
      ring_q  <= ring;
      armed   <= 1'b1;
      pending <= end_s ? ((pending & ~oh_s) | rise_s) : (pending | rise_s);
      if (start_s) begin
        state    <= PLAY;
        busy     <= 1'b1;
        cur_ch   <= start_ch_s;
        cur_step <= '0;
        cnt      <= '0;
        speaker  <= 1'b0;
        fresh    <= 1'b1;
`ifdef ALARM_REPEAT_EN
        rep      <= 4'd0;
`endif
      end else if (idle_s) begin
        state    <= IDLE;
        busy     <= 1'b0;
        cur_ch   <= '0;
        cur_step <= '0;
        cnt      <= '0;
        speaker  <= 1'b0;
        fresh    <= 1'b0;
      end else if (adv_s) begin
        fresh   <= 1'b0;
        cnt     <= '0;
        speaker <= 1'b0;
        if (last_step_s) begin
          cur_step <= '0;
`ifdef ALARM_REPEAT_EN
          rep      <= rep + 4'd1;
`endif
        end else begin
          cur_step <= cur_step + SW'(1);
        end
      end else begin
        fresh <= 1'b0;
        if (cnt == half_s - DIV_W'(1)) begin
          cnt     <= '0;
          speaker <= ~speaker;
        end else begin
          cnt <= cnt + DIV_W'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_alarm_sequencer.sv
// Self-checking bench for alarm_sequencer: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a rule-level behavioural model.
module tb_alarm_sequencer;
  localparam int N_CH = 4, STEPS = 4, DIV_W = 8, BASE_HALF = 2, STEP_HALF = 1, REPEATS = 2;
`ifdef ALARM_REPEAT_EN
  localparam int PLAYS = REPEATS;
`else
  localparam int PLAYS = 1;
`endif

  logic clk = 1'b0, rst = 1'b1, tick = 1'b0, stop = 1'b0;
  logic [N_CH-1:0] ring = '0;
  logic speaker, busy;
  logic [1:0] cur_ch, cur_step;
  logic [N_CH-1:0] pending;

  int checks = 0, errors = 0;
  bit cmp_en = 1'b0;

  alarm_sequencer #(.N_CH(N_CH), .STEPS(STEPS), .DIV_W(DIV_W), .BASE_HALF(BASE_HALF),
                    .STEP_HALF(STEP_HALF), .REPEATS(REPEATS)) dut (
    .clk(clk), .rst(rst), .clk_1hz_posedge(tick), .ring(ring), .stop(stop),
    .speaker(speaker), .busy(busy), .cur_ch(cur_ch), .cur_step(cur_step), .pending(pending));

  always #5 clk = ~clk;

  // Reference state: which channels wait, who plays, where in the melody, cycles spent in this step.
  bit m_pend[N_CH];
  bit m_prev[N_CH];
  bit m_armed = 1'b0, m_play = 1'b0, m_fresh = 1'b0;
  int m_ch = 0, m_step = 0, m_rep = 0, m_k = 0;

  function automatic int first_waiting(input int skip);
    for (int i = 0; i < N_CH; i++) if (m_pend[i] && i != skip) return i;
    return -1;
  endfunction

  task automatic m_begin(input int ch);
    m_play = 1'b1; m_ch = ch; m_step = 0; m_rep = 0; m_k = 0; m_fresh = 1'b1;
  endtask

  always @(posedge clk) begin
    bit rise[N_CH];
    bit tick_ok, fresh_now;
    int nxt, lo;
    if (rst) begin
      for (int i = 0; i < N_CH; i++) begin m_pend[i] = 1'b0; m_prev[i] = 1'b0; end
      m_armed = 1'b0; m_play = 1'b0; m_fresh = 1'b0;
      m_ch = 0; m_step = 0; m_rep = 0; m_k = 0;
    end else begin
      for (int i = 0; i < N_CH; i++) rise[i] = ring[i] && !m_prev[i] && m_armed;
      fresh_now = m_fresh;
      m_fresh = 1'b0;
      if (!m_play) begin
        lo = first_waiting(-1);
        if (lo >= 0) m_begin(lo);
      end else begin
        tick_ok = tick && !fresh_now;
        lo = first_waiting(-1);
        if (stop || (tick_ok && m_step == STEPS - 1 && m_rep == PLAYS - 1)) begin
          m_pend[m_ch] = 1'b0;
          nxt = first_waiting(-1);
          if (nxt >= 0) m_begin(nxt);
          else begin m_play = 1'b0; m_ch = 0; m_step = 0; m_k = 0; end
        end else if (lo < m_ch) begin
          m_begin(lo);
        end else if (tick_ok) begin
          m_k = 0;
          if (m_step == STEPS - 1) begin m_step = 0; m_rep++; end
          else m_step++;
        end else begin
          m_k++;
        end
      end
      for (int i = 0; i < N_CH; i++) begin
        if (rise[i]) m_pend[i] = 1'b1;
        m_prev[i] = ring[i];
      end
      m_armed = 1'b1;
    end
  end

  function automatic int m_half();
    int t;
    t = (m_ch % 2 == 1) ? (STEPS - 1 - m_step) : m_step;
    return BASE_HALF + t * STEP_HALF;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Every-cycle comparison against the model, half a clock away from the sampling edge.
  always @(negedge clk) begin
    int exp_pend, exp_spk;
    if (cmp_en) begin
      exp_pend = 0;
      for (int i = 0; i < N_CH; i++) if (m_pend[i]) exp_pend |= (1 << i);
      exp_spk = m_play ? ((m_k / m_half()) % 2) : 0;
      chk("busy", int'(busy), int'(m_play));
      chk("cur_ch", int'(cur_ch), m_play ? m_ch : 0);
      chk("cur_step", int'(cur_step), m_play ? m_step : 0);
      chk("pending", int'(pending), exp_pend);
      chk("speaker", int'(speaker), exp_spk);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_tick();
    tick = 1'b1; cyc(1); tick = 1'b0; cyc(2);
  endtask

  task automatic pulse_ring(input logic [N_CH-1:0] v);
    ring = v; cyc(1); ring = '0;
  endtask

  initial begin
    cyc(3);
    cmp_en = 1'b1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_pending", int'(pending), 0);
    chk("rst_speaker", int'(speaker), 0);
    rst = 1'b0;
    cyc(1);

    // Single alarm on channel 0: latency, period-4 tone, four ticks to finish.
    ring = 4'b0001; cyc(1);
    chk("d1_pend", int'(pending), 1);
    chk("d1_busy_early", int'(busy), 0);
    ring = '0; cyc(1);
    chk("d1_busy", int'(busy), 1);
    chk("d1_ch", int'(cur_ch), 0);
    chk("d1_spk0", int'(speaker), 0);
    cyc(1); chk("d1_spk1", int'(speaker), 0);
    cyc(1); chk("d1_spk2", int'(speaker), 1);
    cyc(1); chk("d1_spk3", int'(speaker), 1);
    cyc(1); chk("d1_spk4", int'(speaker), 0);
    repeat (4 * PLAYS) pulse_tick();
    chk("d1_done_busy", int'(busy), 0);
    chk("d1_done_pend", int'(pending), 0);

    // Simultaneous ch1 and ch2: ch1 first, ch2 takes over on ch1's last tick.
    pulse_ring(4'b0110); cyc(1);
    chk("d2_ch1", int'(cur_ch), 1);
    cyc(1);
    repeat (4 * PLAYS - 1) pulse_tick();
    tick = 1'b1; cyc(1); tick = 1'b0;
    chk("d2_ch2", int'(cur_ch), 2);
    chk("d2_step0", int'(cur_step), 0);
    chk("d2_pend", int'(pending), 4);
    cyc(1);
    repeat (4 * PLAYS) pulse_tick();
    chk("d2_idle", int'(busy), 0);

    // Preemption of ch3 at step 2 by ch0.
    pulse_ring(4'b1000); cyc(2);
    pulse_tick(); pulse_tick();
    chk("d3_step2", int'(cur_step), 2);
    pulse_ring(4'b0001); cyc(1);
    chk("d3_pre_ch", int'(cur_ch), 0);
    chk("d3_pre_step", int'(cur_step), 0);
    chk("d3_pre_pend", int'(pending), 9);
    cyc(1);
    repeat (4 * PLAYS - 1) pulse_tick();
    tick = 1'b1; cyc(1); tick = 1'b0;
    chk("d3_back_ch", int'(cur_ch), 3);
    chk("d3_back_step", int'(cur_step), 0);
    cyc(1);
    repeat (4 * PLAYS) pulse_tick();

    // Stop during ch0 step 1 with ch2 waiting.
    pulse_ring(4'b0001); cyc(2);
    pulse_tick();
    pulse_ring(4'b0100); cyc(1);
    stop = 1'b1; cyc(1); stop = 1'b0;
    chk("d4_ch", int'(cur_ch), 2);
    chk("d4_step", int'(cur_step), 0);
    chk("d4_pend", int'(pending), 4);
    cyc(2);
    stop = 1'b1; cyc(1); stop = 1'b0;
    chk("d4_stopped", int'(busy), 0);

    // Reset mid-melody with ring[0] held high through release.
    ring = 4'b0001; cyc(5);
    rst = 1'b1; cyc(1);
    chk("d5_spk", int'(speaker), 0);
    chk("d5_busy", int'(busy), 0);
    rst = 1'b0; cyc(4);
    chk("d5_norestart", int'(busy), 0);
    chk("d5_nopend", int'(pending), 0);
    ring = '0; cyc(2);

    // Randomized traffic; the compare process checks every cycle.
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < N_CH; i++) if ($urandom_range(0, 19) == 0) ring[i] = ~ring[i];
      tick = ($urandom_range(0, 7) == 0);
      stop = ($urandom_range(0, 59) == 0);
      rst  = ($urandom_range(0, 799) == 0);
      cyc(1);
    end
    rst = 1'b0; tick = 1'b0; stop = 1'b0; ring = '0;
    cyc(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
